// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 opcodes,
// FSM states and the iteration count.
package muldiv_pkg;

    localparam int ITER_COUNT = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// 64-bit accumulator with one radix-2 shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_is_div,
    input  logic [2*XLEN-1:0] i_init,
    input  logic [XLEN-1:0]   i_opnd,
    output logic [2*XLEN-1:0] o_acc_next
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   w_addend;
    logic [XLEN:0]     w_sum;
    logic [XLEN+1:0]   w_diff;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;

    // Multiply: {hi, multiplier} -- add multiplicand into hi when lo[0], shift right.
    assign w_addend   = r_acc[0] ? i_opnd : {XLEN{1'b0}};
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, w_addend};
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    // Divide: {remainder, dividend} -- shift left one, keep the trial difference if non-negative.
    assign w_diff     = {1'b0, r_acc[2*XLEN-1:XLEN-1]} - {2'b00, i_opnd};
    assign w_div_next = {(w_diff[XLEN+1] ? r_acc[2*XLEN-2:XLEN-1] : w_diff[XLEN-1:0]),
                         r_acc[XLEN-2:0], ~w_diff[XLEN+1]};

    assign o_acc_next = i_is_div ? w_div_next : w_mul_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_init;
        end else if (i_step) begin
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: captures operands as magnitudes,
// runs 32 iterations, and applies the result sign on the way into DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          r_state;
    logic [5:0]      r_cnt;
    logic [2:0]      r_f3;
    logic [XLEN-1:0] r_opnd;
    logic            r_neg;
    logic [XLEN-1:0] r_result;
    logic            r_done;

    logic              w_accept;
    logic              w_is_div;
    logic              w_a_signed;
    logic              w_b_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_neg;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_final;

    assign w_accept   = (r_state == ST_IDLE) && start && !kill;
    assign w_is_div   = f3_is_div(funct3);
    assign w_a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                        (funct3 == F3_DIV)  || (funct3 == F3_REM);
    assign w_b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    assign w_a_neg    = w_a_signed && op_a[XLEN-1];
    assign w_b_neg    = w_b_signed && op_b[XLEN-1];
    assign w_a_mag    = w_a_neg ? -op_a : op_a;
    assign w_b_mag    = w_b_neg ? -op_b : op_b;
    // Remainder follows the dividend; product and quotient follow the XOR.
    assign w_neg      = (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);

    assign w_div_zero    = w_is_div && (op_b == '0);
    assign w_ovf         = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                           (op_a == MIN_NEG) && (op_b == {XLEN{1'b1}});
    assign w_special     = w_div_zero || w_ovf;
    assign w_special_res = w_div_zero ? (funct3[1] ? op_a : {XLEN{1'b1}})
                                      : (funct3[1] ? {XLEN{1'b0}} : MIN_NEG);

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept && !w_special),
        .i_step     (r_state == ST_CALC),
        .i_is_div   (f3_is_div(r_f3)),
        .i_init     ({{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)}),
        .i_opnd     (r_opnd),
        .o_acc_next (w_acc_next)
    );

    assign w_prod_s = r_neg ? -w_acc_next : w_acc_next;
    assign w_quo_s  = r_neg ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    assign w_rem_s  = r_neg ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        w_final = w_prod_s[2*XLEN-1:XLEN];
        case (r_f3)
            F3_MUL:          w_final = w_prod_s[XLEN-1:0];
            F3_DIV, F3_DIVU: w_final = w_quo_s;
            F3_REM, F3_REMU: w_final = w_rem_s;
            default:         w_final = w_prod_s[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_f3     <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_f3   <= funct3;
                        r_neg  <= w_neg;
                        r_opnd <= w_is_div ? w_b_mag : w_a_mag;
                        r_cnt  <= '0;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (kill) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt == 6'(ITER_COUNT - 1)) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign stall  = rst_n && (w_accept || (r_state == ST_CALC));
    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: arithmetic vectors, special
// cases, latency, kill and mid-operation reset.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        kill;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_compared = 0;
  int n_mismatched = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = 32'h0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .kill   (kill),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One operation: start in cycle T0, expect done in cycle T0+exp_lat.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int cyc;
    int stall_cnt;
    logic seen;
    logic [31:0] exp_v;
    @(posedge clk); #1;
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    @(negedge clk);
    check({tag, "_stall_t0"}, stall, 1);
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom_range(0, 7)); op_a = $urandom; op_b = $urandom;
    exp_q.push_back(exp_res);
    cyc = 1; stall_cnt = 0; seen = 1'b0;
    while (!seen && cyc <= 40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else begin
        if (stall) stall_cnt++;
        cyc++;
      end
    end
    exp_v = exp_q.pop_front();
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_stall_cycles"}, stall_cnt, exp_lat - 1);
    check({tag, "_stall_done"}, stall, 0);
    check({tag, "_result"}, result, exp_v);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_after"}, busy, 0);
    check({tag, "_result_hold"}, result, exp_v);
    last_res = exp_v;
  endtask

  task automatic watch_no_done(input string tag);
    int pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check({tag, "_no_done"}, pulses, 0);
    check({tag, "_result_kept"}, result, last_res);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; kill = 1'b0; funct3 = 3'b000; op_a = 32'd1; op_b = 32'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;

    run_op("mul_neg",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu_max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("mulh_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("div_neg",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",      3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",      3'b111, 32'd100,      32'd7,        32'd2,        33);

    // kill in CALC at T0+10
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
    check("kill_busy", busy, 0);
    watch_no_done("kill");

    // start and kill together in IDLE
    @(posedge clk); #1;
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    check("startkill_stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    @(negedge clk);
    check("startkill_busy", busy, 0);
    watch_no_done("startkill");

    run_op("divu_zero", 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu_zero", 3'b111, 32'd5,        32'd0,        32'd5,        1);
    run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // reset at T0+20 of a MUL
    @(posedge clk); #1;
    start = 1'b1; funct3 = 3'b000; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b1;
    @(negedge clk);
    check("midrst_stall", stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 32'h0);
    check("midrst_done", done, 0);
    last_res = 32'h0;
    watch_no_done("midrst");

    run_op("mul_small", 3'b000, 32'd3,        32'd4,        32'd12,       33);
    run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-003 Port clk SHALL be an input, 1 bit: rising-edge clock.
REQ-004 Port rst_n SHALL be an input, 1 bit: synchronous active-low reset.
REQ-005 Port start SHALL be an input, 1 bit: EX stage presents an RV32M instruction.
REQ-006 Port funct3 SHALL be an input, 3 bits: RV32M operation select (inst[14:12]).
REQ-007 Port op_a SHALL be an input, XLEN bits: rs1 value (ReadData1).
REQ-008 Port op_b SHALL be an input, XLEN bits: rs2 value (ReadData2).
REQ-009 Port kill SHALL be an input, 1 bit: pipeline flush that aborts the operation in flight.
REQ-010 Port stall SHALL be an output, 1 bit: freezes the pipeline front end and the EX stage.
REQ-011 Port busy SHALL be an output, 1 bit: the FSM is not in IDLE.
REQ-012 Port done SHALL be an output, 1 bit: 1-cycle pulse marking result as valid.
REQ-013 Port result SHALL be an output, XLEN bits: MUL/DIV/REM result.

Function
REQ-014 funct3 SHALL decode as: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-015 FSM states SHALL be IDLE, CALC and DONE.
- IDLE->CALC when start=1 and kill=0.
- CALC->DONE after 32 iterations.
- DONE->IDLE always.
REQ-016 In IDLE with start=1, kill=0, the block SHALL capture funct3, op_a and op_b; later input changes SHALL be ignored until return to IDLE.
REQ-017 Signed operands SHALL be converted to magnitudes at capture; the sign of the result SHALL be applied in the DONE-entry cycle.
- Product sign: sign(a) XOR sign(b); MULHSU treats op_b as unsigned.
- Quotient sign: sign(a) XOR sign(b).
- Remainder sign: sign of the dividend.
REQ-018 Multiply SHALL be radix-2 shift-add over a 64-bit accumulator, one bit per cycle, for 32 CALC cycles.
- MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
REQ-019 Divide SHALL be restoring shift-subtract, one quotient bit per cycle, for 32 CALC cycles.
REQ-020 Normal latency: start accepted at edge T0 -> done=1 and result valid in cycle T0+33.
REQ-021 Divide-by-zero (op_b=0, DIV/DIVU/REM/REMU) SHALL skip CALC and go IDLE->DONE, with done in cycle T0+1.
- DIV and DIVU return 0xFFFFFFFF.
- REM and REMU return op_a.
REQ-022 Signed overflow (DIV/REM with op_a=0x80000000, op_b=0xFFFFFFFF) SHALL take the DONE-direct path.
- DIV returns 0x80000000.
- REM returns 0.
REQ-023 stall SHALL equal (state==IDLE & start & ~kill) | (state==CALC); stall SHALL be 0 in DONE so the pipeline advances and captures result.
REQ-024 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-025 done SHALL be high for exactly one cycle, in DONE only.
REQ-026 result SHALL update only on DONE entry and SHALL hold its value until the next DONE.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 kill SHALL have priority over start in the same cycle.
REQ-029 kill in CALC or DONE SHALL force IDLE at the next edge.
- done SHALL be suppressed if kill arrives in CALC.
- result SHALL NOT be modified by a killed operation.
REQ-030 The iteration counter SHALL be 6 bits; it SHALL be 0 on CALC entry and terminate at 31; it SHALL never wrap while in CALC.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force state=IDLE, counter=0, accumulator=0, result=0, done=0 and busy=0 in the following cycle.
REQ-032 stall SHALL be 0 during reset regardless of start.
REQ-033 Reset asserted mid-operation SHALL abort it with no done pulse.

Structure
REQ-034 Package muldiv_pkg SHALL hold the funct3 opcode constants, the FSM state enumeration, and the iteration count constant 32.
REQ-035 The block SHALL instantiate one sub-module, muldiv_iter, holding the 64-bit accumulator/remainder register and the per-cycle add/subtract step.
REQ-036 The FSM, capture, sign handling, special-case detection and output registers SHALL reside in muldiv_unit.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB, done in cycle T0+33, stall high cycles T0..T0+32.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF with done at T0+1; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- DIV started, kill at T0+10 -> busy=0 at T0+11, no done, result unchanged; start and kill together in IDLE -> no operation.
- rst_n=0 at T0+20 of a MUL -> cycle after, busy=0, result=0, no done; a new MUL 3*4 afterwards -> 12.
